// File: rtl/spi_arb_pkg.sv
// Shared FSM state type and default parameter values for the SPI arbiter.
package spi_arb_pkg;

    localparam int NREQ_DEF        = 4;
    localparam int DWIDTH_DEF      = 8;
    localparam int TIMEOUT_CYC_DEF = 64;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3,
        RESP      = 3'd4
    } arb_state_e;

    // Index width that stays at least one bit wide for tiny requester counts.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit after last_grant, wrapping.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDXW = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] last_grant,
    output logic [NREQ-1:0] win_oh,
    output logic [IDXW-1:0] win_idx
);

    always_comb begin
        int   cand;
        logic found;
        win_oh  = '0;
        win_idx = '0;
        found   = 1'b0;
        cand    = 0;
        // Offset 1..NREQ so the previous winner is considered last.
        for (int k = 1; k <= NREQ; k++) begin
            cand = (int'(last_grant) + k) % NREQ;
            if (!found && req[cand]) begin
                found        = 1'b1;
                win_oh[cand] = 1'b1;
                win_idx      = IDXW'(cand);
            end
        end
    end

endmodule

// File: rtl/spi_arbiter.sv
// Round-robin arbiter sharing one SPI master core among NREQ requesters.
// Define SPI_ARB_TIMEOUT_EN to add a transfer watchdog that reports via err.
module spi_arbiter
    import spi_arb_pkg::*;
#(
    parameter int NREQ        = NREQ_DEF,
    parameter int DWIDTH      = DWIDTH_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*DWIDTH-1:0] wdata,
    output logic [NREQ-1:0]        gnt,
    output logic [NREQ-1:0]        ack,
    output logic [DWIDTH-1:0]      rdata,
    output logic                   err,
    output logic                   core_cs,
    output logic                   core_wr,
    output logic                   core_rd,
    output logic [DWIDTH-1:0]      core_din,
    input  logic [DWIDTH-1:0]      core_dout,
    input  logic                   core_done
);

    localparam int IDXW = idx_width(NREQ);

    if (NREQ < 2 || NREQ > 8 || DWIDTH < 1 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("spi_arbiter: illegal parameter set");
    end

    arb_state_e      state;
    logic [IDXW-1:0] last_grant;
    logic [IDXW-1:0] win_idx;
    logic [NREQ-1:0] pick_oh;
    logic [IDXW-1:0] pick_idx;
    logic            tmo_hit;

    rr_pick #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_rr_pick (
        .req        (req),
        .last_grant (last_grant),
        .win_oh     (pick_oh),
        .win_idx    (pick_idx)
    );

    // This arbiter only issues write-with-readback transfers.
    assign core_rd = 1'b0;

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int CNTW = $clog2(TIMEOUT_CYC + 1);

    logic [CNTW-1:0] tmo_cnt;
    logic            err_r;
    logic            in_wait;

    assign in_wait = (state == WAIT_BUSY) || (state == WAIT_DONE);
    assign tmo_hit = in_wait && (tmo_cnt == CNTW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt <= '0;
            err_r   <= 1'b0;
        end else begin
            if (state == ISSUE) begin
                tmo_cnt <= '0;
            end else if (in_wait) begin
                tmo_cnt <= tmo_cnt + CNTW'(1);
            end
            // A real completion in the same cycle as the limit wins.
            err_r <= tmo_hit && !(state == WAIT_DONE && core_done);
        end
    end

    assign err = err_r;
`else
    assign tmo_hit = 1'b0;
    assign err     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            gnt        <= '0;
            ack        <= '0;
            rdata      <= '0;
            core_cs    <= 1'b0;
            core_wr    <= 1'b0;
            core_din   <= '0;
            win_idx    <= '0;
            last_grant <= IDXW'(NREQ - 1);
        end else begin
            ack     <= '0;
            core_cs <= 1'b0;
            core_wr <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req && core_done) begin
                        gnt      <= pick_oh;
                        win_idx  <= pick_idx;
                        core_cs  <= 1'b1;
                        core_wr  <= 1'b1;
                        core_din <= wdata[int'(pick_idx)*DWIDTH +: DWIDTH];
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (tmo_hit) begin
                        ack   <= gnt;
                        rdata <= '0;
                        state <= RESP;
                    end else if (!core_done) begin
                        state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (core_done) begin
                        ack   <= gnt;
                        rdata <= core_dout;
                        state <= RESP;
                    end else if (tmo_hit) begin
                        ack   <= gnt;
                        rdata <= '0;
                        state <= RESP;
                    end
                end
                RESP: begin
                    gnt        <= '0;
                    last_grant <= win_idx;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_arbiter.sv
// Bench for spi_arbiter: per-cycle reference model plus directed scenarios.
module tb_spi_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int TMO  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [NREQ*DW-1:0] wdata;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   ack;
    logic [DW-1:0]     rdata;
    logic              err;
    logic              core_cs;
    logic              core_wr;
    logic              core_rd;
    logic [DW-1:0]     core_din;
    logic [DW-1:0]     core_dout;
    logic              core_done;

    spi_arbiter #(
        .NREQ        (NREQ),
        .DWIDTH      (DW),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .wdata     (wdata),
        .gnt       (gnt),
        .ack       (ack),
        .rdata     (rdata),
        .err       (err),
        .core_cs   (core_cs),
        .core_wr   (core_wr),
        .core_rd   (core_rd),
        .core_din  (core_din),
        .core_dout (core_dout),
        .core_done (core_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // SPI master stand-in: busy for three cycles, answers with the byte XOR 8'h99.
    logic          slv_idle = 1'b1;
    logic          slv_stuck;
    logic          force_busy;
    int            slv_cnt = 0;
    logic [DW-1:0] slv_resp = '0;

    assign core_done = slv_idle && !force_busy;

    initial begin
        core_dout = '0;
        forever begin
            @(posedge clk); #1;
            if (slv_cnt > 0) begin
                slv_cnt--;
                if (slv_cnt == 0) begin
                    core_dout = slv_resp;
                    slv_idle  = 1'b1;
                end
            end else if (core_cs && core_wr && !slv_stuck) begin
                slv_resp = core_din ^ 8'h99;
                slv_cnt  = 3;
                slv_idle = 1'b0;
            end
        end
    end

    function automatic int oh2idx(input logic [NREQ-1:0] v);
        for (int i = 0; i < NREQ; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic int rr_next(input logic [NREQ-1:0] r, input int last);
        for (int k = 1; k <= NREQ; k++) if (r[(last + k) % NREQ]) return (last + k) % NREQ;
        return -1;
    endfunction

    // Reference model state and event logs
    logic [NREQ-1:0] e_gnt, e_ack;
    logic [DW-1:0]   e_rdata, e_din;
    logic            e_err, e_cs;
    bit              m_valid = 0, chk_on = 0;
    bit              m_busy, m_in_issue, m_saw_low, m_in_resp, done_now;
    int              m_win, m_last, m_wcnt;
    int              cyc = 0;
    logic [NREQ-1:0] prev_gnt = '0;
    int gnt_log[$], ack_log[$], rd_log[$], err_log[$], din_log[$], gnt_cyc[$], ack_cyc[$];

    always @(negedge clk) begin
        cyc++;
        if (chk_on) begin
            chk("gnt", 32'(gnt), 32'(e_gnt));
            chk("ack", 32'(ack), 32'(e_ack));
            chk("rdata", 32'(rdata), 32'(e_rdata));
            chk("err", 32'(err), 32'(e_err));
            chk("core_cs", 32'(core_cs), 32'(e_cs));
            chk("core_wr", 32'(core_wr), 32'(e_cs));
            chk("core_rd", 32'(core_rd), 32'd0);
            if (e_cs) chk("core_din", 32'(core_din), 32'(e_din));
        end
        if (gnt != '0 && prev_gnt == '0) begin
            gnt_log.push_back(oh2idx(gnt));
            gnt_cyc.push_back(cyc);
        end
        prev_gnt = gnt;
        if (core_cs) din_log.push_back(int'(core_din));
        if (ack != '0) begin
            ack_log.push_back(oh2idx(ack));
            rd_log.push_back(int'(rdata));
            err_log.push_back(int'(err));
            ack_cyc.push_back(cyc);
        end
        // Predict what the next clock edge must produce from the inputs now present.
        if (rst) begin
            e_gnt = '0; e_ack = '0; e_rdata = '0; e_err = 1'b0; e_cs = 1'b0; e_din = '0;
            m_busy = 0; m_last = NREQ - 1; m_valid = 1;
        end else if (m_valid) begin
            e_ack = '0; e_err = 1'b0; e_cs = 1'b0;
            if (!m_busy) begin
                if (req != '0 && core_done) begin
                    m_win = rr_next(req, m_last);
                    e_gnt = NREQ'(1) << m_win;
                    e_cs  = 1'b1;
                    e_din = wdata[m_win*DW +: DW];
                    m_busy = 1; m_in_issue = 1; m_saw_low = 0; m_in_resp = 0; m_wcnt = 0;
                end
            end else if (m_in_resp) begin
                e_gnt = '0; m_busy = 0; m_last = m_win; m_in_resp = 0;
            end else if (m_in_issue) begin
                m_in_issue = 0;
            end else begin
                done_now = m_saw_low && core_done;
                if (!core_done) m_saw_low = 1;
                if (done_now) begin
                    e_ack = e_gnt; e_rdata = core_dout; m_in_resp = 1;
                end
`ifdef SPI_ARB_TIMEOUT_EN
                else if (m_wcnt == TMO - 1) begin
                    e_ack = e_gnt; e_rdata = '0; e_err = 1'b1; m_in_resp = 1;
                end
                m_wcnt++;
`endif
            end
        end
        if (m_valid) chk_on = 1;
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic settle(input int n);
        repeat (n) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1; tick(); tick(); rst = 1'b0;
    endtask

    task automatic clear_logs();
        gnt_log.delete(); ack_log.delete(); rd_log.delete(); err_log.delete();
        din_log.delete(); gnt_cyc.delete(); ack_cyc.delete();
    endtask

    task automatic wait_acks(input string name, input int n, input int budget, input bit drop);
        int got = 0;
        for (int c = 0; c < budget && got < n; c++) begin
            tick();
            if (ack != '0) begin
                got++;
                if (drop) req = req & ~ack;
            end
        end
        chk({name, "_acks_in_budget"}, 32'(got), 32'(n));
    endtask

    int t2_idx[5] = '{0, 1, 2, 3, 0};
    int t2_din[5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
    int t2_rd[5]  = '{8'h88, 8'hBB, 8'hAA, 8'hDD, 8'h88};

    initial begin
        rst = 1'b1; req = '0; wdata = '0; slv_stuck = 1'b0; force_busy = 1'b0;
        do_reset();
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        chk("rst_cs", 32'(core_cs), 32'd0);
        chk("rst_din", 32'(core_din), 32'd0);
        chk("rst_err", 32'(err), 32'd0);

        // Single request from requester 0
        clear_logs();
        wdata = {8'h44, 8'h33, 8'h22, 8'hA5};
        req   = 4'b0001;
        tick();
        chk("t1_gnt_next_cycle", 32'(gnt), 32'h1);
        chk("t1_issue_cs", 32'(core_cs), 32'd1);
        chk("t1_issue_din", 32'(core_din), 32'hA5);
        wait_acks("t1", 1, 30, 1);
        chk("t1_rdata", 32'(rdata), 32'h3C);
        chk("t1_err", 32'(err), 32'd0);
        settle(3);
        chk("t1_issue_count", 32'(din_log.size()), 32'd1);
        chk("t1_ack_idx", 32'(ack_log[0]), 32'd0);

        // All four requesting continuously
        do_reset();
        clear_logs();
        wdata = {8'h44, 8'h33, 8'h22, 8'h11};
        req   = 4'b1111;
        wait_acks("t2", 5, 80, 0);
        req = '0;
        settle(3);
        chk("t2_nack", 32'(ack_log.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t2_ack_order%0d", i), 32'(ack_log[i]), 32'(t2_idx[i]));
            chk($sformatf("t2_din%0d", i), 32'(din_log[i]), 32'(t2_din[i]));
            chk($sformatf("t2_rdata%0d", i), 32'(rd_log[i]), 32'(t2_rd[i]));
        end

        // Requester 2 drops during WAIT_DONE; requester 0 pulses while busy
        do_reset();
        clear_logs();
        wdata = {8'h0F, 8'h5A, 8'h22, 8'h11};
        req   = 4'b1100;
        tick();
        chk("t3_gnt2", 32'(gnt), 32'h4);
        tick(); tick();
        req = 4'b1001;
        tick();
        req = 4'b1000;
        wait_acks("t3", 2, 40, 1);
        settle(3);
        chk("t3_nack", 32'(ack_log.size()), 32'd2);
        chk("t3_ack_first", 32'(ack_log[0]), 32'd2);
        chk("t3_ack_second", 32'(ack_log[1]), 32'd3);
        chk("t3_rdata_first", 32'(rd_log[0]), 32'hC3);
        chk("t3_rdata_second", 32'(rd_log[1]), 32'h96);

        // Reset in the middle of a transfer
        do_reset();
        clear_logs();
        req = 4'b0010;
        tick();
        chk("t4_gnt1", 32'(gnt), 32'h2);
        tick(); tick();
        rst = 1'b1;
        req = 4'b0011;
        tick();
        rst = 1'b0;
        chk("t4_gnt_cleared", 32'(gnt), 32'd0);
        chk("t4_cs_low", 32'(core_cs), 32'd0);
        chk("t4_wr_low", 32'(core_wr), 32'd0);
        chk("t4_no_ack", 32'(ack), 32'd0);
        wait_acks("t4", 2, 60, 1);
        settle(3);
        chk("t4_nack", 32'(ack_log.size()), 32'd2);
        chk("t4_first_ack_req0", 32'(ack_log[0]), 32'd0);
        chk("t4_regrant_req0", 32'(gnt_log[1]), 32'd0);

        // Master busy when request arrives
        do_reset();
        clear_logs();
        force_busy = 1'b1;
        req = 4'b0001;
        settle(5);
        chk("t5_no_gnt_while_busy", 32'(gnt), 32'd0);
        force_busy = 1'b0;
        tick();
        chk("t5_gnt_after_done", 32'(gnt), 32'h1);
        wait_acks("t5", 1, 30, 1);
        settle(2);
        chk("t5_nack", 32'(ack_log.size()), 32'd1);

        // Master never goes busy after ISSUE
        do_reset();
        clear_logs();
        slv_stuck = 1'b1;
        req = 4'b0001;
`ifdef SPI_ARB_TIMEOUT_EN
        wait_acks("t6", 1, 40, 1);
        settle(2);
        chk("t6_nack", 32'(ack_log.size()), 32'd1);
        chk("t6_err", 32'(err_log[0]), 32'd1);
        chk("t6_rdata_zero", 32'(rd_log[0]), 32'd0);
        chk("t6_latency", 32'(ack_cyc[0] - gnt_cyc[0]), 32'd17);
`else
        settle(40);
        chk("t6_no_ack", 32'(ack_log.size()), 32'd0);
        chk("t6_gnt_held", 32'(gnt), 32'h1);
        chk("t6_err_zero", 32'(err), 32'd0);
`endif
        slv_stuck = 1'b0;
        req = '0;
        do_reset();
        settle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
